// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage and the stages next to it.
// Holds the stage FSM encoding, the default widths and the MEM/WB bundle.
package mem_stage_pkg;

    localparam int DW_DEF = 16;
    localparam int RW_DEF = 3;
    localparam int CNT_W  = 16;

    localparam logic [CNT_W-1:0] STALL_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // MEM/WB bundle at the default widths, shared with the writeback stage.
    typedef struct packed {
        logic [DW_DEF-1:0] data;
        logic [RW_DEF-1:0] dest;
        logic              en;
    } mem_wb_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == STALL_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads the next bundle every cycle, or an all-zero bubble.
// Asynchronous active-low clear.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bubble_i,
    input  logic [DW-1:0] data_i,
    input  logic [RW-1:0] dest_i,
    input  logic          en_i,
    output logic [DW-1:0] data_o,
    output logic [RW-1:0] dest_o,
    output logic          en_o
);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] dest;
        logic          en;
    } wb_bundle_t;

    wb_bundle_t wb_d;
    wb_bundle_t wb_q;

    // A bubble clears the whole bundle, not just en, so a dead slot reads as zero.
    always_comb begin
        wb_d = '{data: data_i, dest: dest_i, en: en_i};
        if (bubble_i) begin
            wb_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign data_o = wb_q.data;
    assign dest_o = wb_q.dest;
    assign en_o   = wb_q.en;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack handshake, stalls upstream
// while an access is outstanding, and feeds the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    ex_alu_res,
    input  logic [DW-1:0]    ex_store_data,
    input  logic [RW-1:0]    ex_op_dest,
    input  logic             ex_mem_write_en,
    input  logic             ex_wb_mux,
    input  logic             ex_wb_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DW-1:0]    dmem_addr,
    output logic [DW-1:0]    dmem_wdata,
    input  logic [DW-1:0]    dmem_rdata,
    input  logic             dmem_ack,
    output logic             mem_stall,
    output logic [DW-1:0]    mem_wb_data,
    output logic [RW-1:0]    mem_wb_dest,
    output logic             mem_wb_en,
    output logic [CNT_W-1:0] stall_cnt
);

    mem_state_e state_q, state_d;

    logic [DW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic             we_q;
    logic [RW-1:0]    dest_q;
    logic             wb_en_q;
    logic             wb_mux_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic          is_mem_op;
    logic          hold_load;
    logic          wb_bubble;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_dest;
    logic          wb_en;

    assign is_mem_op = ex_mem_write_en | ex_wb_mux;

    // Gated by rst so the stall drops the instant reset asserts, even with a
    // memory op still sitting on the EX/MEM inputs.
    assign mem_stall = rst & ((state_q == ST_BUSY) ||
                              ((state_q == ST_IDLE) && is_mem_op));

    // NOTE: every signal assigned in this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        wb_bubble = 1'b1;
        wb_data   = '0;
        wb_dest   = '0;
        wb_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_mem_op) begin
                    hold_load = 1'b1;
                    state_d   = ST_BUSY;
                end else begin
                    wb_bubble = 1'b0;
                    wb_data   = ex_alu_res;
                    wb_dest   = ex_op_dest;
                    wb_en     = ex_wb_en;
                end
            end
            ST_BUSY: begin
                if (dmem_ack) begin
                    wb_bubble = 1'b0;
                    // A store with wb_mux also set still writes back its address.
                    wb_data   = (wb_mux_q && !we_q) ? dmem_rdata : addr_q;
                    wb_dest   = dest_q;
                    wb_en     = wb_en_q;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                // EX/MEM still shows the completed op here; it must not re-issue.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cnt_d = mem_stall ? sat_inc(cnt_q) : cnt_q;

    // NOTE: non-blocking assignments here so every register samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            dest_q   <= '0;
            wb_en_q  <= 1'b0;
            wb_mux_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hold_load) begin
                addr_q   <= ex_alu_res;
                wdata_q  <= ex_store_data;
                we_q     <= ex_mem_write_en;
                dest_q   <= ex_op_dest;
                wb_en_q  <= ex_wb_en;
                wb_mux_q <= ex_wb_mux;
            end
        end
    end

    // Request fields come straight from the hold registers, so they stay stable
    // for the whole BUSY stretch regardless of what EX/MEM does.
    assign dmem_req   = (state_q == ST_BUSY);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign stall_cnt  = cnt_q;

    mem_wb_reg #(
        .DW (DW),
        .RW (RW)
    ) u_mem_wb_reg (
        .clk      (clk),
        .rst_n    (rst),
        .bubble_i (wb_bubble),
        .data_i   (wb_data),
        .dest_i   (wb_dest),
        .en_i     (wb_en),
        .data_o   (mem_wb_data),
        .dest_o   (mem_wb_dest),
        .en_o     (mem_wb_en)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a per-cycle vector table for the single-cycle and
// immediate-ack paths, plus hand sequences for delayed ack, reset and saturation.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [15:0] ex_alu_res;
    logic [15:0] ex_store_data;
    logic [2:0]  ex_op_dest;
    logic        ex_mem_write_en;
    logic        ex_wb_mux;
    logic        ex_wb_en;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic [15:0] mem_wb_data;
    logic [2:0]  mem_wb_dest;
    logic        mem_wb_en;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .ex_alu_res      (ex_alu_res),
        .ex_store_data   (ex_store_data),
        .ex_op_dest      (ex_op_dest),
        .ex_mem_write_en (ex_mem_write_en),
        .ex_wb_mux       (ex_wb_mux),
        .ex_wb_en        (ex_wb_en),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ack        (dmem_ack),
        .mem_stall       (mem_stall),
        .mem_wb_data     (mem_wb_data),
        .mem_wb_dest     (mem_wb_dest),
        .mem_wb_en       (mem_wb_en),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] alu;
        logic [15:0] sdata;
        logic [2:0]  dest;
        logic        we;
        logic        mux;
        logic        wben;
        logic        ack;
        logic [15:0] rdata;
        logic        x_stall;
        logic        x_req;
        logic        x_we;
        logic [15:0] x_addr;
        logic [15:0] x_wdata;
        logic [15:0] x_data;
        logic [2:0]  x_dest;
        logic        x_en;
    } vec_t;

    vec_t vec [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [15:0] alu, input logic [15:0] sdata, input logic [2:0] dest,
                          input logic we, input logic mux, input logic wben);
        ex_alu_res      = alu;
        ex_store_data   = sdata;
        ex_op_dest      = dest;
        ex_mem_write_en = we;
        ex_wb_mux       = mux;
        ex_wb_en        = wben;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        set_ex(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // Reset state, with a load on the inputs to show the stall is held low.
        rst = 1'b0;
        set_ex(16'h0010, 16'h0, 3'd5, 1'b0, 1'b1, 1'b1);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h0;
        #3;
        check("rst_req",   dmem_req,    1'b0);
        check("rst_we",    dmem_we,     1'b0);
        check("rst_addr",  dmem_addr,   16'h0);
        check("rst_wdata", dmem_wdata,  16'h0);
        check("rst_stall", mem_stall,   1'b0);
        check("rst_data",  mem_wb_data, 16'h0);
        check("rst_dest",  mem_wb_dest, 3'd0);
        check("rst_en",    mem_wb_en,   1'b0);
        check("rst_cnt",   stall_cnt,   16'h0);

        // alu, sdata, dest, we, mux, wben, ack, rdata | stall, req, we, addr, wdata | data, dest, en
        vec[0] = '{16'h0042, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000,
                   1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0042, 3'd3, 1'b1};
        vec[1] = '{16'h1111, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000,
                   1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1111, 3'd1, 1'b0};
        vec[2] = '{16'h0010, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000,
                   1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0};
        vec[3] = '{16'h0010, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 16'hBEEF,
                   1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3'd5, 1'b1};
        vec[4] = '{16'h0010, 16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 16'hDEAD,
                   1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0};
        vec[5] = '{16'h0077, 16'h0000, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000,
                   1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0077, 3'd2, 1'b1};
        vec[6] = '{16'h00A5, 16'h0000, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 16'hDEAD,
                   1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00A5, 3'd7, 1'b1};
        vec[7] = '{16'h0030, 16'h5555, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000,
                   1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0};
        vec[8] = '{16'h0030, 16'h5555, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 16'h9999,
                   1'b1, 1'b1, 1'b1, 16'h0030, 16'h5555, 16'h0030, 3'd4, 1'b1};
        vec[9] = '{16'h0030, 16'h5555, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000,
                   1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0};

        apply_reset();
        for (int i = 0; i < 10; i++) begin
            set_ex(vec[i].alu, vec[i].sdata, vec[i].dest, vec[i].we, vec[i].mux, vec[i].wben);
            dmem_ack   = vec[i].ack;
            dmem_rdata = vec[i].rdata;
            #1;
            check($sformatf("v%0d_stall", i), mem_stall, vec[i].x_stall);
            check($sformatf("v%0d_req", i),   dmem_req,  vec[i].x_req);
            if (vec[i].x_req) begin
                check($sformatf("v%0d_we", i),    dmem_we,    vec[i].x_we);
                check($sformatf("v%0d_addr", i),  dmem_addr,  vec[i].x_addr);
                check($sformatf("v%0d_wdata", i), dmem_wdata, vec[i].x_wdata);
            end
            tick();
            check($sformatf("v%0d_wb_data", i), mem_wb_data, vec[i].x_data);
            check($sformatf("v%0d_wb_dest", i), mem_wb_dest, vec[i].x_dest);
            check($sformatf("v%0d_wb_en", i),   mem_wb_en,   vec[i].x_en);
        end
        check("table_stall_cnt", stall_cnt, 16'd4);

        // Store with ack on the 4th BUSY cycle.
        apply_reset();
        set_ex(16'h0020, 16'h1234, 3'd6, 1'b1, 1'b0, 1'b0);
        dmem_ack = 1'b0;
        #1;
        check("st_detect_stall", mem_stall, 1'b1);
        check("st_detect_req",   dmem_req,  1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            dmem_ack   = (i == 3);
            dmem_rdata = 16'hFFFF;
            #1;
            check($sformatf("st_busy%0d_req", i),   dmem_req,   1'b1);
            check($sformatf("st_busy%0d_we", i),    dmem_we,    1'b1);
            check($sformatf("st_busy%0d_addr", i),  dmem_addr,  16'h0020);
            check($sformatf("st_busy%0d_wdata", i), dmem_wdata, 16'h1234);
            check($sformatf("st_busy%0d_stall", i), mem_stall,  1'b1);
            tick();
            check($sformatf("st_busy%0d_wb_en", i), mem_wb_en,  1'b0);
        end
        dmem_ack = 1'b0;
        #1;
        check("st_done_stall", mem_stall, 1'b0);
        check("st_done_req",   dmem_req,  1'b0);
        tick();
        check("st_after_wb_en", mem_wb_en, 1'b0);
        check("st_stall_cnt",   stall_cnt, 16'd5);

        // Reset dropped during BUSY, with the load still on the inputs.
        apply_reset();
        set_ex(16'h0040, 16'h7777, 3'd3, 1'b1, 1'b0, 1'b0);
        #1;
        tick();
        check("rm_busy_req",  dmem_req,  1'b1);
        check("rm_busy_addr", dmem_addr, 16'h0040);
        #2;
        rst = 1'b0;
        #1;
        check("rm_req",   dmem_req,    1'b0);
        check("rm_stall", mem_stall,   1'b0);
        check("rm_we",    dmem_we,     1'b0);
        check("rm_addr",  dmem_addr,   16'h0);
        check("rm_wdata", dmem_wdata,  16'h0);
        check("rm_data",  mem_wb_data, 16'h0);
        check("rm_dest",  mem_wb_dest, 3'd0);
        check("rm_en",    mem_wb_en,   1'b0);
        check("rm_cnt",   stall_cnt,   16'h0);
        @(posedge clk);
        #1;
        set_ex(16'h0ABC, 16'h0, 3'd2, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check("rm_alu_stall", mem_stall, 1'b0);
        tick();
        check("rm_alu_data", mem_wb_data, 16'h0ABC);
        check("rm_alu_dest", mem_wb_dest, 3'd2);
        check("rm_alu_en",   mem_wb_en,   1'b1);
        check("rm_alu_req",  dmem_req,    1'b0);

        // Long load stall drives the counter into saturation.
        apply_reset();
        set_ex(16'h0100, 16'h0, 3'd1, 1'b0, 1'b1, 1'b1);
        dmem_ack = 1'b0;
        #1;
        tick();
        begin
            int n;
            n = 1;
            for (int k = 0; k < 65545; k++) begin
                tick();
                n++;
                if (n == 65534) check("sat_fffe", stall_cnt, 16'hFFFE);
                if (n == 65535) check("sat_ffff", stall_cnt, 16'hFFFF);
            end
        end
        check("sat_hold",     stall_cnt, 16'hFFFF);
        check("sat_req_held", dmem_req,  1'b1);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hABCD;
        #1;
        tick();
        check("sat_ack_cnt",  stall_cnt,   16'hFFFF);
        check("sat_ack_data", mem_wb_data, 16'hABCD);
        check("sat_ack_en",   mem_wb_en,   1'b1);
        dmem_ack = 1'b0;
        tick();
        check("sat_done_cnt", stall_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
